// File: rtl/test_bit_mem_scanner.sv
// ---------------------------------------------------------------------------
// test_bit_mem_scanner
//
// Read-side sequencer for a single-bit memory. On an accepted start it walks
// a range of addresses (wrapping at DEPTH), samples the memory's
// combinational read data and streams one bit per valid/ready handshake. Each
// bit it reads is also written into a DEPTH-bit snapshot (word). The memory is
// never written.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a scan (sampled only while idle)
//   first_addr first address of the scan (>= DEPTH is treated as 0)
//   len        bits to read; 0 or > DEPTH means DEPTH
//   mem_addr   memory address (always the next address to fetch)
//   mem_we     memory write enable, tied low
//   mem_rdata  memory combinational read data for mem_addr
//   busy       high from the cycle after an accepted start through DONE
//   out_valid  streamed bit is valid
//   out_ready  consumer accepts the bit on out_valid & out_ready
//   out_data   streamed bit
//   out_addr   address the streamed bit came from
//   out_last   streamed bit is the final one of the scan
//   done       one-cycle pulse after the last bit is accepted
//   word       snapshot of the bits visited by the latest scan, others 0
// ---------------------------------------------------------------------------
module test_bit_mem_scanner #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic              mem_rdata,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              done,
    output logic [DEPTH-1:0]  word
);

    localparam int unsigned LenW = ADDR_W + 1;
    localparam logic [LenW-1:0]   DepthLen = LenW'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStream,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;      // next address to fetch
    logic [LenW-1:0]   rem_q;       // bits not yet fetched
    logic              out_valid_q;
    logic              out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              out_last_q;
    logic [DEPTH-1:0]  word_q;

    logic              handshake;
    logic              fetch_en;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] start_addr;
    logic [LenW-1:0]   eff_len;

    always_comb begin
        handshake = out_valid_q & out_ready;
        // A fetch happens on entry to streaming and on every non-final
        // handshake, which keeps the stream at one bit per cycle.
        fetch_en  = (state_q == StFetch) ||
                    ((state_q == StStream) && handshake && !out_last_q);
        addr_inc  = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
        start_addr = ({1'b0, first_addr} >= DepthLen) ? '0 : first_addr;
        eff_len   = ((len == '0) || (len > DepthLen)) ? DepthLen : len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            word_q      <= '0;
        end else begin
            if (fetch_en) begin
                out_data_q     <= mem_rdata;
                out_addr_q     <= addr_q;
                out_last_q     <= (rem_q == LenW'(1));
                word_q[addr_q] <= mem_rdata;
                addr_q         <= addr_inc;
                rem_q          <= rem_q - 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q  <= start_addr;
                        rem_q   <= eff_len;
                        word_q  <= '0;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    out_valid_q <= 1'b1;
                    state_q     <= StStream;
                end
                StStream: begin
                    if (handshake && out_last_q) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_we    = 1'b0;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign word      = word_q;

endmodule
